onehot_scan_decoder: RTL

//  Parametrised, registered binary-to-one-hot decoder with an auto-scan mode.

---
 rtl/onehot_scan_decoder.sv | 119 +++++++++++
 1 files changed

// File: rtl/onehot_scan_decoder.sv
// ============================================================================
// onehot_scan_decoder : registered binary-to-one-hot decoder with auto-scan
// Revision: 1.0
// ============================================================================
`default_nettype none

module onehot_scan_decoder #(
   parameter int SEL_W   = 3,
   parameter int OUT_W   = 1 << SEL_W,
   parameter int DWELL_W = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               en_i,
   input  logic               mode_i,
   input  logic [SEL_W-1:0]   sel_i,
   input  logic               load_i,
   input  logic [DWELL_W-1:0] dwell_i,
   output logic [OUT_W-1:0]   out_o,
   output logic [SEL_W-1:0]   idx_o,
   output logic               wrap_o,
   output logic               err_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_e;

   localparam logic [SEL_W:0]   OUT_W_X  = (SEL_W+1)'(OUT_W);
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_W - 1);

   state_e               state_q, state_d;
   logic [SEL_W-1:0]     idx_q, idx_d;
   logic [DWELL_W-1:0]   cnt_q, cnt_d;
   logic [OUT_W-1:0]     out_q, out_d;
   logic                 wrap_q, wrap_d;
   logic                 err_q, err_d;
   logic                 drive_d;

   logic                 w_sel_ok;
   logic [DWELL_W-1:0]   w_last_cnt;
   logic                 w_step;
   logic [OUT_W-1:0]     w_dec;

   // sel values beyond the populated lines are rejected when OUT_W < 2^SEL_W
   assign w_sel_ok   = ({1'b0, sel_i} < OUT_W_X);
   assign w_last_cnt = (dwell_i == '0) ? '0 : (dwell_i - DWELL_W'(1));
   assign w_step     = (cnt_q >= w_last_cnt);

   for (genvar gi = 0; gi < OUT_W; gi++) begin : g_dec
      assign w_dec[gi] = (idx_d == SEL_W'(gi));
   end

   assign out_d = drive_d ? w_dec : '0;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         wrap_q  <= wrap_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = ST_IDLE;
      idx_d   = idx_q;
      cnt_d   = '0;
      wrap_d  = 1'b0;
      err_d   = 1'b0;
      drive_d = 1'b0;
      if (en_i) begin
         if (!mode_i) begin
            state_d = ST_DIRECT;
            if (w_sel_ok) begin
               idx_d   = sel_i;
               drive_d = 1'b1;
            end else begin
               err_d   = 1'b1;
            end
         end else begin
            state_d = ST_SCAN;
            drive_d = 1'b1;
            if ((state_q != ST_SCAN) || load_i) begin
               idx_d = w_sel_ok ? sel_i : '0;
               err_d = !w_sel_ok;
            end else if (w_step) begin
               if (idx_q == LAST_IDX) begin
                  idx_d  = '0;
                  wrap_d = 1'b1;
               end else begin
                  idx_d  = idx_q + SEL_W'(1);
               end
            end else begin
               cnt_d = cnt_q + DWELL_W'(1);
            end
         end
      end
   end

   assign out_o  = out_q;
   assign idx_o  = idx_q;
   assign wrap_o = wrap_q;
   assign err_o  = err_q;

endmodule

`default_nettype wire
